addsub_serial: RTL and testbench
================================

Name: addsub_serial

Overview:
- Parametrised, multi-cycle two's-complement adder/subtractor.
- Generalises the 4-bit ripple add/sub with overflow to WIDTH bits.
- Processes CHUNK bits per clock through a CHUNK-bit adder slice and a registered inter-chunk carry.
- Valid/ready handshake on both sides; sits between operand-issue logic and the flag/result consumer in the datapath.

Parameters:
- WIDTH, 16, operand/result width in bits. WIDTH >= 2.
- CHUNK, 4, bits processed per cycle. 1 <= CHUNK <= WIDTH and WIDTH % CHUNK == 0; elaboration error otherwise.
- NCHUNK (localparam), WIDTH/CHUNK, number of compute cycles.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand request valid.
- in_ready  output  1  block can accept operands.
- se  input  1  mode: 0 = A+B, 1 = A-B. Sampled on accept.
- A  input  WIDTH  operand A. Sampled on accept.
- B  input  WIDTH  operand B. Sampled on accept.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- S  output  WIDTH  sum/difference, modulo 2^WIDTH.
- C  output  1  carry out of MSB. For subtract, 1 = no borrow.
- V  output  1  signed overflow.
- Z  output  1  S == 0.
- N  output  1  S[WIDTH-1].

Behaviour:
- Reset: rst=1 at an edge returns FSM to IDLE and clears chunk counter and carry register. in_ready=1 after the edge; out_valid=0; S, C, V, Z, N all = 0. Reset overrides every other event, including mid-RUN and DONE; partial results are discarded.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready: latch A and B^{WIDTH{se}} (i.e. A and B when se=0, A and ~B when se=1); set carry register = se; set chunk counter = 0; go to RUN.
- RUN:
  - in_ready=0; in_valid and operand changes are ignored.
  - Each cycle adds chunk i = bits [i*CHUNK +: CHUNK] of A and the latched B operand, plus the carry register. Writes that slice of S; updates carry register with the slice carry-out; increments i.
  - On the last chunk (i = NCHUNK-1), also capture:
    - C = carry out of bit WIDTH-1
    - V = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1
    - Z and N from the full result
  - Then go to DONE.
  - Latency: out_valid rises exactly NCHUNK cycles after the accept edge.
- DONE:
  - out_valid=1, in_ready=0.
  - S, C, V, Z, N are held stable while out_valid && !out_ready.
  - On out_valid&&out_ready: go to IDLE; out_valid=0 and in_ready=1 on the next cycle. No same-cycle accept of a new operation.
  - S and flags keep their last values in IDLE until the next operation overwrites them.
- Arithmetic: results wrap modulo 2^WIDTH; no saturation. Operands are read only at accept, so later input changes do not affect the result.
- Throughput: one operation per NCHUNK+2 cycles when out_ready is tied high.
- CHUNK = WIDTH degenerates to a single RUN cycle; behaviour must be identical to the multi-chunk case apart from latency.

Test Plan (WIDTH=16, CHUNK=4 unless stated):
- se=0, A=0x7FFF, B=0x0001 -> S=0x8000, C=0, V=1, N=1, Z=0. out_valid asserted exactly 4 cycles after the accept edge.
- se=1, A=0x0005, B=0x0003 -> S=0x0002, C=1, V=0. Then se=1, A=0x0000, B=0x0001 -> S=0xFFFF, C=0, V=0, N=1.
- se=1, A=0x8000, B=0x0001 -> S=0x7FFF, C=1, V=1. Then se=0, A=0xFFFF, B=0x0001 -> S=0x0000, C=1, V=0, Z=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> S and flags stable, in_ready=0 throughout. During RUN, toggle in_valid/A/B -> result unaffected.
- Reset: assert rst in the 2nd RUN cycle -> next cycle in_ready=1, out_valid=0, all outputs 0. A subsequent op (0x1234+0x1111) -> S=0x2345.
- Parameter sweep: CHUNK=16 and CHUNK=1, 200 random ops each vs. golden model (S, C, V, Z, N). Latency = 1 and 16 cycles respectively.

Source files
------------

// File: rtl/addsub_serial.sv
// ---------------------------------------------------------------------------
// addsub_serial
// Multi-cycle two's-complement adder/subtractor. Each RUN cycle adds one
// CHUNK-bit slice of the operands and keeps the carry between slices in a
// register, so a WIDTH-bit operation takes WIDTH/CHUNK compute cycles.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   in_valid   operand request valid
//   in_ready   block is idle and can take operands
//   se         0 = A+B, 1 = A-B (sampled on accept)
//   A, B       operands (sampled on accept)
//   out_valid  result available
//   out_ready  consumer takes the result
//   S          result modulo 2^WIDTH
//   C          carry out of the MSB (for subtract, 1 = no borrow)
//   V          signed overflow
//   Z          S == 0
//   N          S[WIDTH-1]
// ---------------------------------------------------------------------------
module addsub_serial #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             se,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             C,
    output logic             V,
    output logic             Z,
    output logic             N
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    generate
        if (WIDTH < 2 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_param_check
            $error("addsub_serial: illegal WIDTH/CHUNK combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_reg, a_next;
    logic [WIDTH-1:0] b_reg, b_next;      // B already inverted for subtract
    logic [WIDTH-1:0] s_reg, s_next;
    logic             carry_reg, carry_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic             c_reg, c_next;
    logic             v_reg, v_next;
    logic             z_reg, z_next;
    logic             n_reg, n_next;

    // Slice views of the latched operands, selected by the chunk counter.
    logic [CHUNK-1:0] a_chunk [NCHUNK];
    logic [CHUNK-1:0] b_chunk [NCHUNK];
    logic [CHUNK-1:0] a_slice;
    logic [CHUNK-1:0] b_slice;
    logic [CHUNK:0]   slice_sum;
    logic [WIDTH-1:0] s_run;
    logic             last_chunk;

    genvar gi;
    generate
        for (gi = 0; gi < NCHUNK; gi++) begin : g_chunk
            assign a_chunk[gi] = a_reg[gi*CHUNK +: CHUNK];
            assign b_chunk[gi] = b_reg[gi*CHUNK +: CHUNK];
            // Only the slice addressed by the counter takes the new sum;
            // the other slices keep what earlier cycles wrote.
            assign s_run[gi*CHUNK +: CHUNK] = (cnt_reg == CW'(gi)) ? slice_sum[CHUNK-1:0]
                                                                   : s_reg[gi*CHUNK +: CHUNK];
        end
    endgenerate

    assign a_slice    = a_chunk[cnt_reg];
    assign b_slice    = b_chunk[cnt_reg];
    assign slice_sum  = {1'b0, a_slice} + {1'b0, b_slice} + {{CHUNK{1'b0}}, carry_reg};
    assign last_chunk = (cnt_reg == CW'(NCHUNK - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            s_reg     <= '0;
            carry_reg <= 1'b0;
            cnt_reg   <= '0;
            c_reg     <= 1'b0;
            v_reg     <= 1'b0;
            z_reg     <= 1'b0;
            n_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            s_reg     <= s_next;
            carry_reg <= carry_next;
            cnt_reg   <= cnt_next;
            c_reg     <= c_next;
            v_reg     <= v_next;
            z_reg     <= z_next;
            n_reg     <= n_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        s_next     = s_reg;
        carry_next = carry_reg;
        cnt_next   = cnt_reg;
        c_next     = c_reg;
        v_next     = v_reg;
        z_next     = z_reg;
        n_next     = n_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;

        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    // Subtract is A + ~B + 1: invert B here and seed the carry.
                    a_next     = A;
                    b_next     = B ^ {WIDTH{se}};
                    carry_next = se;
                    cnt_next   = '0;
                    state_next = RUN;
                end
            end
            RUN: begin
                s_next     = s_run;
                carry_next = slice_sum[CHUNK];
                cnt_next   = cnt_reg + CW'(1);
                if (last_chunk) begin
                    c_next     = slice_sum[CHUNK];
                    // Carry-in XOR carry-out of the MSB equals "operand signs
                    // agree but result sign differs".
                    v_next     = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                                 (s_run[WIDTH-1] != a_reg[WIDTH-1]);
                    z_next     = (s_run == '0);
                    n_next     = s_run[WIDTH-1];
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign S = s_reg;
    assign C = c_reg;
    assign V = v_reg;
    assign Z = z_reg;
    assign N = n_reg;

endmodule

// File: tb/tb_addsub_serial.sv
// ---------------------------------------------------------------------------
// tb_addsub_serial
// Three instances (CHUNK = 4, 16, 1; WIDTH = 16) driven from one operand
// stream. Expected results come from a plain-arithmetic model and are queued
// per instance; a monitor per instance pops and compares on each handshake,
// and also checks latency and output stability under backpressure.
// ---------------------------------------------------------------------------
module tb_addsub_serial;

    localparam int W    = 16;
    localparam int NDUT = 3;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         v;
        logic         z;
        logic         n;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            se;
    logic [W-1:0]    a_in;
    logic [W-1:0]    b_in;
    logic [NDUT-1:0] in_ready;
    logic [NDUT-1:0] out_valid;
    logic [NDUT-1:0] out_ready;
    logic [NDUT-1:0] c_o;
    logic [NDUT-1:0] v_o;
    logic [NDUT-1:0] z_o;
    logic [NDUT-1:0] n_o;
    logic [W-1:0]    s_o [NDUT];

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int rdy_mode    = 0;   // 0 = always ready, 1 = random, 2 = never ready

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // ------------------------------------------------------------------
    // Reference model: plain integer arithmetic.
    // ------------------------------------------------------------------
    function automatic exp_t model(input logic sub, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t        e;
        int          sa;
        int          sb;
        int          r;
        logic [W:0]  full;
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (sub) begin
            full = {1'b0, a} - {1'b0, b};
            e.c  = (a >= b);
            r    = sa - sb;
        end else begin
            full = {1'b0, a} + {1'b0, b};
            e.c  = full[W];
            r    = sa + sb;
        end
        e.s = full[W-1:0];
        e.v = (r > 32767) || (r < -32768);
        e.z = (e.s == '0);
        e.n = e.s[W-1];
        return e;
    endfunction

    function automatic void push_all(input exp_t e);
        q0.push_back(e);
        q1.push_back(e);
        q2.push_back(e);
    endfunction

    function automatic void flush_all();
        q0.delete();
        q1.delete();
        q2.delete();
    endfunction

    function automatic int qsize(input int i);
        case (i)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic exp_t pop_exp(input int i);
        exp_t e;
        case (i)
            0:       e = q0.pop_front();
            1:       e = q1.pop_front();
            default: e = q2.pop_front();
        endcase
        return e;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s dut%0d: got %h expected %h (t=%0t)", name, idx, act, expv, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // DUTs and per-instance monitors
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NDUT; gi++) begin : g_dut
            localparam int CHK = (gi == 0) ? 4 : (gi == 1) ? 16 : 1;
            localparam int LAT = W / CHK;

            addsub_serial #(.WIDTH(W), .CHUNK(CHK)) dut (
                .clk       (clk),
                .rst       (rst),
                .in_valid  (in_valid),
                .in_ready  (in_ready[gi]),
                .se        (se),
                .A         (a_in),
                .B         (b_in),
                .out_valid (out_valid[gi]),
                .out_ready (out_ready[gi]),
                .S         (s_o[gi]),
                .C         (c_o[gi]),
                .V         (v_o[gi]),
                .Z         (z_o[gi]),
                .N         (n_o[gi])
            );

            logic        hold;
            logic        prev_valid;
            logic [19:0] held;
            int          acc;
            exp_t        e;

            initial begin
                hold       = 1'b0;
                prev_valid = 1'b0;
                held       = '0;
                acc        = 0;
                forever begin
                    @(negedge clk);
                    if (rst) begin
                        hold       = 1'b0;
                        prev_valid = 1'b0;
                    end else begin
                        if (in_valid && in_ready[gi])
                            acc = cyc + 1;
                        if (out_valid[gi] && !prev_valid)
                            check("latency", gi, cyc - acc, LAT);
                        if (hold) begin
                            check("hold_stable", gi, {s_o[gi], c_o[gi], v_o[gi], z_o[gi], n_o[gi]}, held);
                            check("hold_valid", gi, out_valid[gi], 1);
                            check("hold_in_ready", gi, in_ready[gi], 0);
                        end
                        if (out_valid[gi]) begin
                            if (out_ready[gi]) begin
                                hold = 1'b0;
                                if (qsize(gi) == 0) begin
                                    vectors++;
                                    miscompares++;
                                    $display("FAIL unexpected_result dut%0d: got S=%h expected no result", gi, s_o[gi]);
                                end else begin
                                    e = pop_exp(gi);
                                    check("S", gi, s_o[gi], e.s);
                                    check("CVZN", gi, {c_o[gi], v_o[gi], z_o[gi], n_o[gi]}, {e.c, e.v, e.z, e.n});
                                    $display("txn dut%0d chunk=%0d S=%h C=%b V=%b Z=%b N=%b", gi, CHK,
                                             s_o[gi], c_o[gi], v_o[gi], z_o[gi], n_o[gi]);
                                end
                            end else begin
                                hold = 1'b1;
                                held = {s_o[gi], c_o[gi], v_o[gi], z_o[gi], n_o[gi]};
                            end
                        end else begin
                            hold = 1'b0;
                        end
                        prev_valid = out_valid[gi];
                    end
                end
            end
        end
    endgenerate

    // Consumer ready pattern
    initial forever begin
        @(posedge clk);
        #1;
        for (int i = 0; i < NDUT; i++)
            out_ready[i] = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic wait_idle();
        int t = 0;
        while (in_ready !== {NDUT{1'b1}}) begin
            @(posedge clk);
            #1;
            t++;
            if (t > 500) begin
                vectors++;
                miscompares++;
                $display("FAIL idle_timeout: got in_ready=%b expected %b", in_ready, {NDUT{1'b1}});
                break;
            end
        end
    endtask

    task automatic start_op(input logic sub, input logic [W-1:0] a, input logic [W-1:0] b);
        wait_idle();
        se       = sub;
        a_in     = a;
        b_in     = b;
        in_valid = 1'b1;
        push_all(model(sub, a, b));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Garbage on the inputs while every instance is still busy.
    task automatic junk_inputs();
        repeat (2) begin
            in_valid = 1'($urandom_range(0, 1));
            se       = 1'($urandom_range(0, 1));
            a_in     = W'($urandom);
            b_in     = W'($urandom);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    function automatic logic [W-1:0] pick_operand();
        logic [W-1:0] corners [5];
        corners = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF};
        if ($urandom_range(0, 3) == 0)
            return corners[$urandom_range(0, 4)];
        return W'($urandom);
    endfunction

    initial begin
        int t;
        rst       = 1'b1;
        in_valid  = 1'b0;
        se        = 1'b0;
        a_in      = '0;
        b_in      = '0;
        out_ready = '1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < NDUT; i++) begin
            check("reset_in_ready", i, in_ready[i], 1);
            check("reset_out_valid", i, out_valid[i], 0);
            check("reset_outputs", i, {s_o[i], c_o[i], v_o[i], z_o[i], n_o[i]}, 0);
        end
        @(posedge clk);
        #1;

        // Directed arithmetic cases
        start_op(1'b0, 16'h7FFF, 16'h0001);
        start_op(1'b1, 16'h0005, 16'h0003);
        start_op(1'b1, 16'h0000, 16'h0001);
        start_op(1'b1, 16'h8000, 16'h0001);
        junk_inputs();
        start_op(1'b0, 16'hFFFF, 16'h0001);

        // Backpressure with input activity during RUN
        wait_idle();
        rdy_mode = 2;
        @(posedge clk);
        #1;
        start_op(1'b0, 16'h4321, 16'h1234);
        junk_inputs();
        t = 0;
        while (out_valid !== {NDUT{1'b1}} && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("bp_all_valid", 0, out_valid, {NDUT{1'b1}});
        repeat (5) @(posedge clk);
        #1;
        rdy_mode = 0;

        // Reset in the second RUN cycle discards the operation
        start_op(1'b0, 16'hAAAA, 16'h1111);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        flush_all();
        @(negedge clk);
        for (int i = 0; i < NDUT; i++) begin
            check("midrun_rst_in_ready", i, in_ready[i], 1);
            check("midrun_rst_out_valid", i, out_valid[i], 0);
            check("midrun_rst_outputs", i, {s_o[i], c_o[i], v_o[i], z_o[i], n_o[i]}, 0);
        end
        @(posedge clk);
        #1;
        start_op(1'b0, 16'h1234, 16'h1111);

        // Random operations with random consumer readiness
        rdy_mode = 1;
        for (int k = 0; k < 200; k++) begin
            start_op(1'($urandom_range(0, 1)), pick_operand(), pick_operand());
            if ((k % 4) == 0)
                junk_inputs();
        end
        rdy_mode = 0;
        wait_idle();
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < NDUT; i++)
            check("drain", i, qsize(i), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
